// File: rtl/fmap_uart_reader_pkg.sv
// Shared definitions for the fmap_bank UART readback engine:
// bus widths, FSM encoding and the label header byte format.
package fmap_uart_reader_pkg;

  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned LABEL_W = 4;
  localparam int unsigned ST_W    = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_LAT  = 3'd3,
    ST_SEND = 3'd4,
    ST_GAP  = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  // Transfer request captured on start.
  typedef struct packed {
    logic [ADDR_W-1:0]  base_addr;
    logic [LEN_W-1:0]   num_bytes;
    logic               send_label;
    logic [LABEL_W-1:0] label;
  } xfer_cmd_t;

  // Header byte sent ahead of the window: label in the low nibble, upper bits zero.
  function automatic logic [DATA_W-1:0] label_hdr(input logic [LABEL_W-1:0] lbl);
    return {(DATA_W-LABEL_W)'(0), lbl};
  endfunction

endpackage

// File: rtl/fmap_uart_reader_if.sv
// fmap_bank port B read bus plus UART TX byte handshake, as seen by the reader.
interface fmap_uart_reader_if
  import fmap_uart_reader_pkg::*;
;

  logic [ADDR_W-1:0] fbank_raddr;
  logic              fbank_ren;
  logic [DATA_W-1:0] fdata_r;
  logic [DATA_W-1:0] tdata;
  logic              tdata_req;
  logic              tdata_ready;

  modport master (
    output fbank_raddr,
    output fbank_ren,
    input  fdata_r,
    output tdata,
    output tdata_req,
    input  tdata_ready
  );

  modport slave (
    input  fbank_raddr,
    input  fbank_ren,
    output fdata_r,
    input  tdata,
    input  tdata_req,
    output tdata_ready
  );

endinterface

// File: rtl/fmap_uart_reader.sv
// Streams a window of fmap_bank out over the UART TX byte handshake after start,
// optionally preceded by a one-byte label header.
module fmap_uart_reader
  import fmap_uart_reader_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    num_bytes,
  input  logic                send_label,
  input  logic [LABEL_W-1:0]  label,
  fmap_uart_reader_if.master  bus,
  output logic                busy,
  output logic                done
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LABEL_W-1:0] lbl_q, lbl_d;
  logic [DATA_W-1:0]  tbuf_q, tbuf_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic               ren_q, ren_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  xfer_cmd_t          cmd_c;

  assign cmd_c = '{base_addr:  base_addr,
                   num_bytes:  num_bytes,
                   send_label: send_label,
                   label:      label};

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lbl_q   <= '0;
      tbuf_q  <= '0;
      raddr_q <= '0;
      ren_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lbl_q   <= lbl_d;
      tbuf_q  <= tbuf_d;
      raddr_q <= raddr_d;
      ren_q   <= ren_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; ren/raddr/req/done are computed one cycle ahead so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lbl_d   = lbl_q;
    tbuf_d  = tbuf_q;
    raddr_d = raddr_q;
    ren_d   = 1'b0;
    req_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d  = cmd_c.base_addr;
          cnt_d  = cmd_c.num_bytes;
          lbl_d  = cmd_c.label;
          busy_d = 1'b1;
          if (cmd_c.send_label)              state_d = ST_HDR;
          else if (cmd_c.num_bytes == '0)    state_d = ST_FIN;
          else                               state_d = ST_RD;
        end
      end
      ST_HDR: begin
        tbuf_d  = label_hdr(lbl_q);
        state_d = ST_SEND;
      end
      ST_RD: begin
        state_d = ST_LAT;
      end
      ST_LAT: begin
        tbuf_d  = bus.fdata_r;
        ptr_d   = ptr_q + ADDR_W'(1);
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (bus.tdata_ready) begin
          req_d   = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // Dead cycle lets the UART drop ready before we look at it again.
        state_d = (cnt_q != '0) ? ST_RD : ST_FIN;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Port B is driven only while in RD; raddr holds its last value otherwise.
    if (state_d == ST_RD) begin
      ren_d   = 1'b1;
      raddr_d = ptr_d;
    end
  end

  assign bus.fbank_raddr = raddr_q;
  assign bus.fbank_ren   = ren_q;
  assign bus.tdata       = tbuf_q;
  assign bus.tdata_req   = req_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_fmap_uart_reader.sv
// Self-checking bench for fmap_uart_reader: BRAM and UART TX models with a
// byte/address scoreboard, table-driven transfers plus stall and reset sequences.
module tb_fmap_uart_reader;
  import fmap_uart_reader_pkg::*;

  localparam int TMO = 3000;

  typedef struct {
    logic [ADDR_W-1:0]  base;
    logic [LEN_W-1:0]   num;
    logic               sl;
    logic [LABEL_W-1:0] lbl;
    int                 gap;
    int                 exp_reqs;
    int                 exp_rens;
    int                 exp_lat;   // 0: latency not checked
  } vec_t;

  logic               clk;
  logic               rstn;
  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [LEN_W-1:0]   num_bytes;
  logic               send_label;
  logic [LABEL_W-1:0] label;
  logic               busy;
  logic               done;

  fmap_uart_reader_if bus ();

  fmap_uart_reader dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .base_addr  (base_addr),
    .num_bytes  (num_bytes),
    .send_label (send_label),
    .label      (label),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1-cycle-latency BRAM model.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] fdata;
  always @(posedge clk) if (bus.fbank_ren) fdata <= mem[bus.fbank_raddr];
  assign bus.fdata_r = fdata;

  // UART TX model: ready drops after req, returns gap+1 cycles later unless stalled.
  int   gap;
  logic stall;
  logic rdy;
  int   ucnt;
  always @(posedge clk) begin
    if (!rstn) begin
      rdy  <= 1'b1;
      ucnt <= 0;
    end else if (bus.tdata_req) begin
      rdy  <= 1'b0;
      ucnt <= gap;
    end else if (!rdy && !stall) begin
      if (ucnt == 0) rdy <= 1'b1;
      else           ucnt <= ucnt - 1;
    end
  end
  assign bus.tdata_ready = rdy & ~stall;

  int errors = 0;
  int checks = 0;
  int req_cnt = 0;
  int ren_cnt = 0;
  int done_cnt = 0;
  logic [DATA_W-1:0] exp_byte_q [$];
  logic [ADDR_W-1:0] exp_addr_q [$];
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: advance to negedge and score whatever the DUT produced.
  task automatic step();
    @(negedge clk);
    if (bus.tdata_req) begin
      req_cnt++;
      if (exp_byte_q.size() == 0) check("unexpected_req", 32'(bus.tdata), 32'hFFFF_FFFF);
      else                        check("tdata", 32'(bus.tdata), 32'(exp_byte_q.pop_front()));
    end
    if (bus.fbank_ren) begin
      ren_cnt++;
      if (exp_addr_q.size() == 0) check("unexpected_ren", 32'(bus.fbank_raddr), 32'hFFFF_FFFF);
      else                        check("raddr", 32'(bus.fbank_raddr), 32'(exp_addr_q.pop_front()));
    end
    if (done) done_cnt++;
  endtask

  task automatic push_exp(input vec_t v);
    logic [ADDR_W-1:0] a;
    if (v.sl) exp_byte_q.push_back({4'h0, v.lbl});
    for (int i = 0; i < int'(v.num); i++) begin
      a = v.base + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_byte_q.push_back(mem[a]);
    end
  endtask

  task automatic drive_start(input vec_t v);
    start      = 1'b1;
    base_addr  = v.base;
    num_bytes  = v.num;
    send_label = v.sl;
    label      = v.lbl;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < TMO) begin
      step();
      lat++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int r0, e0, d0, lat;
    r0 = req_cnt; e0 = ren_cnt; d0 = done_cnt;
    gap = v.gap;
    push_exp(v);
    drive_start(v);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(lat);
    if (v.exp_lat != 0) check("done_latency", 32'(lat), 32'(v.exp_lat));
    step();
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_pulse", 32'(done_cnt - d0), 32'd1);
    check("req_count", 32'(req_cnt - r0), 32'(v.exp_reqs));
    check("ren_count", 32'(ren_cnt - e0), 32'(v.exp_rens));
    check("bytes_left", 32'(exp_byte_q.size()), 32'd0);
    check("addrs_left", 32'(exp_addr_q.size()), 32'd0);
    repeat (3) step();
  endtask

  initial begin
    vec_t v;
    int   r0, d0, n, bad, lat;
    logic [DATA_W-1:0] snap;

    rstn = 1'b0; start = 1'b0; base_addr = '0; num_bytes = '0;
    send_label = 1'b0; label = '0; gap = 0; stall = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i * 37 + 5);
    mem[15'h0010] = 8'hA1; mem[15'h0011] = 8'hB2;
    mem[15'h0012] = 8'hC3; mem[15'h0013] = 8'hD4;

    vecs[0] = '{base:15'h0010, num:16'd4, sl:1'b0, lbl:4'h0, gap:0, exp_reqs:4, exp_rens:4, exp_lat:0};
    vecs[1] = '{base:15'h0040, num:16'd2, sl:1'b1, lbl:4'h7, gap:2, exp_reqs:3, exp_rens:2, exp_lat:0};
    vecs[2] = '{base:15'h0000, num:16'd0, sl:1'b0, lbl:4'h0, gap:0, exp_reqs:0, exp_rens:0, exp_lat:2};
    vecs[3] = '{base:15'h7FFF, num:16'd2, sl:1'b0, lbl:4'h0, gap:1, exp_reqs:2, exp_rens:2, exp_lat:0};
    vecs[4] = '{base:15'h0200, num:16'd0, sl:1'b1, lbl:4'hA, gap:0, exp_reqs:1, exp_rens:0, exp_lat:0};
    vecs[5] = '{base:15'h0300, num:16'd6, sl:1'b0, lbl:4'h0, gap:5, exp_reqs:6, exp_rens:6, exp_lat:0};

    repeat (3) step();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_req",   32'(bus.tdata_req), 32'd0);
    check("rst_ren",   32'(bus.fbank_ren), 32'd0);
    check("rst_tdata", 32'(bus.tdata), 32'd0);
    check("rst_raddr", 32'(bus.fbank_raddr), 32'd0);
    rstn = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Long UART stall during byte 2, with a start pulse that must be ignored.
    v = '{base:15'h0080, num:16'd4, sl:1'b0, lbl:4'h0, gap:1, exp_reqs:4, exp_rens:4, exp_lat:0};
    gap = v.gap; r0 = req_cnt; d0 = done_cnt;
    push_exp(v);
    drive_start(v);
    n = 0;
    while (req_cnt - r0 < 1 && n < TMO) begin step(); n++; end
    check("stall_first_req", 32'(req_cnt - r0), 32'd1);
    stall = 1'b1;
    repeat (3) step();
    snap = bus.tdata;
    check("stall_byte2_loaded", 32'(snap), 32'(mem[15'h0081]));
    start = 1'b1; base_addr = 15'h0100; num_bytes = 16'd3; send_label = 1'b1; label = 4'h5;
    step();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 46; i++) begin
      step();
      if (bus.tdata_req || bus.tdata !== snap || !busy) bad++;
    end
    check("stall_quiet", 32'(bad), 32'd0);
    check("stall_req_count", 32'(req_cnt - r0), 32'd1);
    stall = 1'b0;
    wait_done(lat);
    repeat (20) step();
    check("stall_total_reqs", 32'(req_cnt - r0), 32'd4);
    check("stall_one_done", 32'(done_cnt - d0), 32'd1);
    check("stall_bytes_left", 32'(exp_byte_q.size()), 32'd0);

    // Reset in the middle of byte 3 of 10, then a fresh full transfer.
    v = '{base:15'h0020, num:16'd10, sl:1'b0, lbl:4'h0, gap:0, exp_reqs:10, exp_rens:10, exp_lat:0};
    gap = v.gap; r0 = req_cnt;
    push_exp(v);
    drive_start(v);
    n = 0;
    while (req_cnt - r0 < 2 && n < TMO) begin step(); n++; end
    check("abort_two_reqs", 32'(req_cnt - r0), 32'd2);
    repeat (2) step();
    rstn = 1'b0;
    step();
    check("abort_req",  32'(bus.tdata_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ren",  32'(bus.fbank_ren), 32'd0);
    rstn = 1'b1;
    exp_byte_q.delete();
    exp_addr_q.delete();
    d0 = done_cnt; r0 = req_cnt;
    repeat (5) step();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_req",  32'(req_cnt - r0), 32'd0);
    run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
